// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) constants and the inverse-FSM state type for the AES S-box path.
// The S-box and MixColumns stages reuse these definitions.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam logic [7:0] INV_EXP  = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } inv_state_t;

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiply: carry-less product of a and b reduced mod {1,POLY}.
// Also used by MixColumns.
module gf_mul8
    import aes_gf_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: sh walks through a*x^i, reduced on every step.
    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/gf_inverse_seq.sv
// Sequential GF(2^8) power out = in^EXP (inverse by default), square-and-multiply
// over a single shared gf_mul8; feeds the S-box affine stage directly.
module gf_inverse_seq
    import aes_gf_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY,
    parameter logic [7:0] EXP  = INV_EXP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy
);

    if (EXP[7] != 1'b1) begin : g_exp_check
        $error("gf_inverse_seq: EXP[7] must be 1");
    end

    inv_state_t state_q;
    inv_state_t state_d;
    logic [7:0] x_q;
    logic [7:0] r_q;
    logic [2:0] idx_q;
    logic [7:0] out_data_q;
    logic [7:0] mul_b;
    logic [7:0] prod;
    logic       exp_bit;

    assign exp_bit = EXP[idx_q];
    assign mul_b   = (state_q == MUL) ? x_q : r_q;

    gf_mul8 #(
        .POLY(POLY)
    ) u_mul (
        .a(r_q),
        .b(mul_b),
        .p(prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SQR;
                end
            end
            SQR: begin
                if (exp_bit) begin
                    state_d = MUL;
                end else if (idx_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            MUL: begin
                if (idx_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = SQR;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The result register only loads on entry to DONE, so an aborted op never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_d == DONE && state_q != DONE) begin
                out_data_q <= prod;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_q   <= in_data;
                    r_q   <= 8'h01;
                    idx_q <= 3'd7;
                end
            end
            SQR: begin
                r_q <= prod;
                if (!exp_bit && idx_q != 3'd0) begin
                    idx_q <= idx_q - 3'd1;
                end
            end
            MUL: begin
                r_q <= prod;
                if (idx_q != 3'd0) begin
                    idx_q <= idx_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SQR) || (state_q == MUL);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf_inverse_seq.sv
// Scoreboard bench for gf_inverse_seq: stimulus pushes expectations, a negedge
// monitor pops and compares on every output transfer and checks latency.
module tb_gf_inverse_seq;
    import aes_gf_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;

    always #5 clk = ~clk;

    gf_inverse_seq #(
        .POLY(8'h1B),
        .EXP (8'hFE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
        int         acc_cyc;
        bit         chk_sbox;
        logic [7:0] exp_sbox;
    } exp_t;

    exp_t sb_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    bit   rand_rdy = 1'b0;
    bit   prev_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Schoolbook polynomial product followed by long division by 0x11B.
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] t;
        t = 15'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) t = t ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (t[i]) t = t ^ (15'h11B << (i - 8));
        end
        return t[7:0];
    endfunction

    function automatic logic [7:0] inv_ref(input logic [7:0] x);
        logic [7:0] y;
        inv_ref = 8'h00;
        for (int k = 1; k < 256; k++) begin
            y = 8'(k);
            if (x != 8'h00 && gmul_ref(x, y) == 8'h01) inv_ref = y;
        end
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic bit sbox_known(input logic [7:0] d, output logic [7:0] s);
        sbox_known = 1'b1;
        case (d)
            8'h00: s = 8'h63;
            8'h01: s = 8'h7C;
            8'h02: s = 8'h77;
            8'h03: s = 8'h7B;
            8'h10: s = 8'hCA;
            8'h20: s = 8'hB7;
            8'h53: s = 8'hED;
            8'h80: s = 8'hCD;
            8'hAA: s = 8'hAC;
            8'hC9: s = 8'hDD;
            8'hFF: s = 8'h16;
            default: begin
                s = 8'h00;
                sbox_known = 1'b0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd15);
                end
            end
            prev_ov = out_valid;
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check($sformatf("data_%02h", e.din), 32'(out_data), 32'(e.exp));
                if (e.chk_sbox)
                    check($sformatf("sbox_%02h", e.din), 32'(affine(out_data)), 32'(e.exp_sbox));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [7:0] d, input logic [7:0] e, input bit cs,
                         input logic [7:0] es, input bit hold);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        sb_q.push_back('{din: d, exp: e, acc_cyc: cyc, chk_sbox: cs, exp_sbox: es});
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        repeat (20) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] es;
        bit         cs;
        int         n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1: single byte
        issue(8'h53, 8'hCA, 1'b1, 8'hED, 1'b0);
        drain();

        // 2: corner operands back to back
        issue(8'h00, 8'h00, 1'b1, 8'h63, 1'b0);
        issue(8'h01, 8'h01, 1'b1, 8'h7C, 1'b0);
        issue(8'h02, 8'h8D, 1'b1, 8'h77, 1'b0);
        issue(8'hFF, 8'h1C, 1'b1, 8'h16, 1'b0);
        drain();

        // 3: backpressure
        out_ready = 1'b0;
        issue(8'h02, 8'h8D, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h8D);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("done_in_ready_with_out_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_data_held_after", 32'(out_data), 32'h8D);
        drain();

        // 4: in_valid held with changing data while busy
        issue(8'h53, 8'hCA, 1'b1, 8'hED, 1'b1);
        for (int i = 0; i < 13; i++) begin
            in_data = 8'(i * 17 + 3);
            check("busy_while_computing", 32'(busy), 32'd1);
            check("in_ready_while_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // 5: reset mid-operation
        issue(8'h53, 8'hCA, 1'b0, 8'h00, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'h00);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        issue(8'h53, 8'hCA, 1'b1, 8'hED, 1'b0);
        drain();

        // 6: exhaustive sweep with random out_ready
        rand_rdy = 1'b1;
        for (int d = 0; d < 256; d++) begin
            cs = sbox_known(8'(d), es);
            issue(8'(d), inv_ref(8'(d)), cs, es, 1'b0);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
